// File: rtl/modulo_varredura_matriz_param_pkg.sv
// Shared definitions for the parametrised LED-matrix scan path:
// display modes, write-port layer codes and a width helper.
package modulo_varredura_matriz_param_pkg;

    // Display mode selected on the mode input.
    typedef enum logic [1:0] {
        MODE_PO  = 2'b00,
        MODE_AT  = 2'b01,
        MODE_OVL = 2'b10,
        MODE_OFF = 2'b11
    } mode_e;

    // Bit-plane addressed by the write port.
    typedef enum logic {
        LAYER_PO = 1'b0,
        LAYER_AT = 1'b1
    } layer_e;

    // ceil(log2(n)), never less than 1 so that a counter always has a bit.
    function automatic int clog2w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/modulo_prescaler_varredura.sv
// Scan timing: row dwell prescaler, row index, frame counter, blink phase
// and the frame_tick pulse. Runs freely; nothing outside can stall it.
module modulo_prescaler_varredura
    import modulo_varredura_matriz_param_pkg::*;
#(
    parameter  int ROWS      = 5,
    parameter  int PRESC     = 1000,
    parameter  int BLINK_DIV = 50,
    localparam int RW        = clog2w(ROWS)
) (
    input  logic          clk,
    input  logic          clr,
    output logic [RW-1:0] row_idx,
    output logic          blink,
    output logic          frame_tick
);

    localparam int PW = clog2w(PRESC);
    localparam int FW = clog2w(BLINK_DIV);

    logic [PW-1:0] presc_cnt;
    logic [FW-1:0] frame_cnt;
    logic          row_step;
    logic          frame_wrap;
    logic          blink_wrap;

    // Terminal-count decodes for the three cascaded counters.
    always_comb begin
        row_step   = (presc_cnt == PW'(PRESC - 1));
        frame_wrap = row_step && (row_idx == RW'(ROWS - 1));
        blink_wrap = frame_wrap && (frame_cnt == FW'(BLINK_DIV - 1));
    end

    // Prescaler, row index, frame counter, blink phase and frame pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_cnt  <= '0;
            row_idx    <= '0;
            frame_cnt  <= '0;
            blink      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (row_step) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
            if (frame_wrap) begin
                row_idx <= '0;
            end else if (row_step) begin
                row_idx <= row_idx + 1'b1;
            end
            if (blink_wrap) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else if (frame_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/modulo_varredura_matriz_param.sv
// Parametrised LED-matrix scan path for the naval-battle board: PO/AT
// bit-planes with a coordinate write port, row multiplexing with
// selectable display mode and blinking hits, and a running hit count.
//
// Write port: wr_en is a single-cycle strobe with no back-pressure (the
// port is always ready). A strobe sampled on an edge is answered on that
// same edge by exactly one of wr_ack (coordinate in range, bit stored
// unless its plane is being cleared) or wr_err (coordinate out of range,
// nothing stored); the answer is visible for the following cycle.
module modulo_varredura_matriz_param
    import modulo_varredura_matriz_param_pkg::*;
#(
    parameter  int ROWS      = 5,
    parameter  int COLS      = 7,
    parameter  int PRESC     = 1000,
    parameter  int BLINK_DIV = 50,
    localparam int RW        = clog2w(ROWS),
    localparam int CW        = clog2w(COLS),
    localparam int HW        = clog2w(ROWS * COLS + 1)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            wr_en,
    input  logic            wr_layer,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic            wr_data,
    output logic            wr_ack,
    output logic            wr_err,
    input  logic [1:0]      layer_clr,
    input  logic [1:0]      mode,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_out,
    output logic            frame_tick,
    output logic [HW-1:0]   hit_count
);

    logic [COLS-1:0] po [ROWS];
    logic [COLS-1:0] at [ROWS];

    logic [RW-1:0]   row_idx;
    logic            blink;

    logic            wr_ok;
    logic            wr_bad;
    logic [RW-1:0]   row_i;
    logic [CW-1:0]   col_i;
    logic            clr_po;
    logic            clr_at;
    logic            po_bit;
    logic            at_bit;
    logic            po_new;
    logic            at_new;
    logic            old_hit;
    logic            new_hit;
    logic [HW-1:0]   hit_base;
    logic [HW-1:0]   hit_next;

    logic [ROWS-1:0] row_sel_d;
    logic [COLS-1:0] col_d;
    logic [COLS-1:0] po_row;
    logic [COLS-1:0] at_row;

    modulo_prescaler_varredura #(
        .ROWS      (ROWS),
        .PRESC     (PRESC),
        .BLINK_DIV (BLINK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .clr        (clr),
        .row_idx    (row_idx),
        .blink      (blink),
        .frame_tick (frame_tick)
    );

    // Write decode and incremental hit-count update. The addressed cell is
    // evaluated after any same-cycle clear, so a clear followed by a write
    // to the surviving plane counts correctly.
    always_comb begin
        wr_ok    = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
        wr_bad   = wr_en && !wr_ok;
        row_i    = wr_ok ? wr_row : '0;
        col_i    = wr_ok ? wr_col : '0;
        clr_po   = layer_clr[0];
        clr_at   = layer_clr[1];
        po_bit   = clr_po ? 1'b0 : po[row_i][col_i];
        at_bit   = clr_at ? 1'b0 : at[row_i][col_i];
        po_new   = po_bit;
        at_new   = at_bit;
        if (wr_ok && (wr_layer == LAYER_PO) && !clr_po) begin
            po_new = wr_data;
        end
        if (wr_ok && (wr_layer == LAYER_AT) && !clr_at) begin
            at_new = wr_data;
        end
        old_hit  = po_bit & at_bit;
        new_hit  = po_new & at_new;
        hit_base = (clr_po || clr_at) ? '0 : hit_count;
        hit_next = hit_base + HW'(new_hit) - HW'(old_hit);
    end

    // Plane storage: clears first, then the write to a surviving plane.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int r = 0; r < ROWS; r++) begin
                po[r] <= '0;
                at[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (clr_po) begin
                    po[r] <= '0;
                end
                if (clr_at) begin
                    at[r] <= '0;
                end
            end
            if (wr_ok && (wr_layer == LAYER_PO) && !clr_po) begin
                po[row_i][col_i] <= wr_data;
            end
            if (wr_ok && (wr_layer == LAYER_AT) && !clr_at) begin
                at[row_i][col_i] <= wr_data;
            end
        end
    end

    // Write responses and hit counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            hit_count <= '0;
        end else begin
            wr_ack    <= wr_ok;
            wr_err    <= wr_bad;
            hit_count <= hit_next;
        end
    end

    // Display mux for the currently selected row.
    always_comb begin
        row_sel_d = ~(ROWS'(1) << row_idx);
        po_row    = po[row_idx];
        at_row    = at[row_idx];
        col_d     = '0;
        case (mode)
            MODE_PO:  col_d = po_row;
            MODE_AT:  col_d = at_row;
            MODE_OVL: col_d = (at_row & ~po_row)
                            | (po_row & at_row & {COLS{blink}})
                            | (po_row & ~at_row & {COLS{blink}});
            default: begin
                col_d     = '0;
                row_sel_d = '1;
            end
        endcase
    end

    // Registered row/column drive.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            row_sel <= '1;
            col_out <= '0;
        end else begin
            row_sel <= row_sel_d;
            col_out <= col_d;
        end
    end

endmodule

// File: tb/tb_modulo_varredura_matriz_param.sv
// Bench for modulo_varredura_matriz_param with ROWS=5, COLS=7, PRESC=4,
// BLINK_DIV=2. A reference model derives the scan position and blink phase
// from the number of clock edges since reset release and keeps the planes
// as plain bit arrays; hit_count is recounted over the whole grid.
module tb_modulo_varredura_matriz_param;

    localparam int ROWS      = 5;
    localparam int COLS      = 7;
    localparam int PRESC     = 4;
    localparam int BLINK_DIV = 2;
    localparam int RW        = 3;
    localparam int CW        = 3;
    localparam int HW        = 6;
    localparam int FRAME     = PRESC * ROWS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic            wr_en;
    logic            wr_layer;
    logic [RW-1:0]   wr_row;
    logic [CW-1:0]   wr_col;
    logic            wr_data;
    logic            wr_ack;
    logic            wr_err;
    logic [1:0]      layer_clr;
    logic [1:0]      mode;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_out;
    logic            frame_tick;
    logic [HW-1:0]   hit_count;

    int errors = 0;
    int checks = 0;

    modulo_varredura_matriz_param #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .PRESC     (PRESC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_layer   (wr_layer),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .layer_clr  (layer_clr),
        .mode       (mode),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .frame_tick (frame_tick),
        .hit_count  (hit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              mpo [ROWS][COLS];
    bit              mat [ROWS][COLS];
    int              k;
    bit              model_live = 1'b0;
    logic [ROWS-1:0] exp_row_sel;
    logic [COLS-1:0] exp_col;
    logic            exp_tick;
    logic            exp_ack;
    logic            exp_err;
    int              exp_hit;
    int              m_row;
    int              m_blk;
    bit              m_ok;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            k = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    mpo[r][c] = 1'b0;
                    mat[r][c] = 1'b0;
                end
            exp_row_sel = '1;
            exp_col     = '0;
            exp_tick    = 1'b0;
            exp_ack     = 1'b0;
            exp_err     = 1'b0;
            exp_hit     = 0;
            model_live  = 1'b1;
        end else begin
            k = k + 1;
            // Display reflects the row and blink phase in force before this edge.
            m_row = ((k - 1) / PRESC) % ROWS;
            m_blk = (((k - 1) / FRAME) / BLINK_DIV) % 2;
            exp_row_sel = '1;
            exp_row_sel[m_row] = 1'b0;
            exp_col = '0;
            for (int c = 0; c < COLS; c++) begin
                case (mode)
                    2'b00: exp_col[c] = mpo[m_row][c];
                    2'b01: exp_col[c] = mat[m_row][c];
                    2'b10: begin
                        if (mpo[m_row][c]) exp_col[c] = (m_blk == 1);
                        else               exp_col[c] = mat[m_row][c];
                    end
                    default: exp_col[c] = 1'b0;
                endcase
            end
            if (mode == 2'b11) exp_row_sel = '1;
            exp_tick = (k % FRAME == 0);
            m_ok    = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
            exp_ack = wr_en && m_ok;
            exp_err = wr_en && !m_ok;
            if (layer_clr[0])
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) mpo[r][c] = 1'b0;
            if (layer_clr[1])
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) mat[r][c] = 1'b0;
            if (wr_en && m_ok) begin
                if (wr_layer == 1'b0 && !layer_clr[0]) mpo[wr_row][wr_col] = wr_data;
                if (wr_layer == 1'b1 && !layer_clr[1]) mat[wr_row][wr_col] = wr_data;
            end
            exp_hit = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (mpo[r][c] && mat[r][c]) exp_hit++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("row_sel", 32'(row_sel), 32'(exp_row_sel));
            check("col_out", 32'(col_out), 32'(exp_col));
            check("frame_tick", 32'(frame_tick), 32'(exp_tick));
            check("wr_ack", 32'(wr_ack), 32'(exp_ack));
            check("wr_err", 32'(wr_err), 32'(exp_err));
            check("hit_count", 32'(hit_count), 32'(exp_hit));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic layer, input int r, input int c,
                            input logic d, input logic [1:0] lc);
        wr_en     = 1'b1;
        wr_layer  = layer;
        wr_row    = RW'(r);
        wr_col    = CW'(c);
        wr_data   = d;
        layer_clr = lc;
        @(negedge clk);
        wr_en     = 1'b0;
        layer_clr = 2'b00;
    endtask

    task automatic wait_row(input int r);
        logic [ROWS-1:0] tgt;
        bit found;
        tgt   = ~(ROWS'(1) << r);
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (row_sel == tgt) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wait_row_timeout", 32'(found), 32'd1);
    endtask

    // ---------------- directed stimulus ----------------
    logic [ROWS-1:0] scan_tbl [6];
    logic [COLS-1:0] pat_a;
    logic [COLS-1:0] pat_b;
    bit              seen_a;
    bit              seen_b;
    int              nonzero;

    initial begin
        scan_tbl[0] = 5'b11110;
        scan_tbl[1] = 5'b11101;
        scan_tbl[2] = 5'b11011;
        scan_tbl[3] = 5'b10111;
        scan_tbl[4] = 5'b01111;
        scan_tbl[5] = 5'b11110;
        pat_a = 7'b0100000;
        pat_b = 7'b0101000;

        clr = 1'b0; wr_en = 1'b0; wr_layer = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = 1'b0; layer_clr = 2'b00; mode = 2'b00;
        tick(3);
        check("reset_row_sel", 32'(row_sel), 32'h1f);
        check("reset_col_out", 32'(col_out), 32'h0);
        check("reset_hit", 32'(hit_count), 32'h0);

        // Idle scan after release.
        clr = 1'b1;
        tick(1);
        check("scan_step0", 32'(row_sel), 32'(scan_tbl[0]));
        for (int i = 1; i < 6; i++) begin
            tick(PRESC);
            check("scan_step", 32'(row_sel), 32'(scan_tbl[i]));
        end

        // PO(2,3)=1 in mode 00.
        do_write(1'b0, 2, 3, 1'b1, 2'b00);
        check("po_write_ack", 32'(wr_ack), 32'd1);
        wait_row(2);
        tick(1);
        check("po_row2_col", 32'(col_out), 32'b0001000);
        check("po_hit", 32'(hit_count), 32'd0);

        // Overlay with one hit and one miss on row 2.
        mode = 2'b10;
        do_write(1'b1, 2, 3, 1'b1, 2'b00);
        do_write(1'b1, 2, 5, 1'b1, 2'b00);
        check("ovl_hit", 32'(hit_count), 32'd1);
        seen_a = 1'b0; seen_b = 1'b0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            if (row_sel == 5'b11011 && col_out == pat_a) seen_a = 1'b1;
            if (row_sel == 5'b11011 && col_out == pat_b) seen_b = 1'b1;
            tick(1);
        end
        check("blink_phase_off_seen", 32'(seen_a), 32'd1);
        check("blink_phase_on_seen", 32'(seen_b), 32'd1);

        // Out-of-range coordinates.
        do_write(1'b0, 6, 0, 1'b1, 2'b00);
        check("bad_row_err", 32'(wr_err), 32'd1);
        check("bad_row_noack", 32'(wr_ack), 32'd0);
        do_write(1'b1, 0, 7, 1'b1, 2'b00);
        check("bad_col_err", 32'(wr_err), 32'd1);
        check("bad_col_hit", 32'(hit_count), 32'd1);

        // Hit removal, idempotent rewrite, restore.
        do_write(1'b0, 2, 3, 1'b0, 2'b00);
        check("unhit", 32'(hit_count), 32'd0);
        do_write(1'b0, 2, 3, 1'b0, 2'b00);
        check("rewrite_same", 32'(hit_count), 32'd0);
        do_write(1'b0, 2, 3, 1'b1, 2'b00);
        check("rehit", 32'(hit_count), 32'd1);

        // Clear AT with a same-cycle AT write that must be dropped.
        do_write(1'b1, 0, 0, 1'b1, 2'b10);
        check("clr_ack", 32'(wr_ack), 32'd1);
        check("clr_hit", 32'(hit_count), 32'd0);
        mode = 2'b01;
        tick(2);
        nonzero = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            if (col_out != '0) nonzero++;
            tick(1);
        end
        check("at_cleared_cols", 32'(nonzero), 32'd0);

        // Recount after clear, then blank mode.
        do_write(1'b1, 2, 3, 1'b1, 2'b00);
        check("recount_hit", 32'(hit_count), 32'd1);
        mode = 2'b11;
        tick(2);
        check("blank_row_sel", 32'(row_sel), 32'h1f);
        check("blank_col", 32'(col_out), 32'h0);
        mode = 2'b00;

        // Asynchronous reset in the middle of row 3.
        wait_row(3);
        tick(1);
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        check("async_row_sel", 32'(row_sel), 32'h1f);
        check("async_col", 32'(col_out), 32'h0);
        check("async_hit", 32'(hit_count), 32'h0);
        tick(2);
        clr = 1'b1;
        tick(1);
        check("restart_row0", 32'(row_sel), 32'b11110);
        nonzero = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (col_out != '0) nonzero++;
            tick(1);
        end
        check("restart_planes_zero", 32'(nonzero), 32'd0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modulo_varredura_matriz_param.md
Name: modulo_varredura_matriz_param

Overview:
- Parametrised successor of the fixed 7x5 LED-matrix scan path of the naval-battle board.
- Holds two bit-planes, positions (PO) and attacks (AT), each ROWS x COLS, written through a coordinate write port.
- Time-multiplexes rows onto the physical matrix with a programmable dwell and a selectable display mode, including blinking hits.
- Keeps a running count of hit cells (PO=1 and AT=1) for the status logic and 7-segment path.

Parameters:
ROWS, 5, number of matrix rows (2..16)
COLS, 7, number of matrix columns (2..16)
PRESC, 1000, clock cycles each row is driven (>=2)
BLINK_DIV, 50, full frames per blink-phase toggle (>=1)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous reset, active-low
wr_en  in  1  single-cycle write strobe
wr_layer  in  1  0 = PO plane, 1 = AT plane
wr_row  in  RW=clog2(ROWS)  target row
wr_col  in  CW=clog2(COLS)  target column
wr_data  in  1  bit value to store
wr_ack  out  1  pulse: write accepted
wr_err  out  1  pulse: coordinate out of range, no write
layer_clr  in  2  bit0 clears PO, bit1 clears AT (synchronous, one cycle)
mode  in  2  00 PO, 01 AT, 10 overlay, 11 blank
row_sel  out  ROWS  one-hot active-low row drive
col_out  out  COLS  active-high column data
frame_tick  out  1  pulse on row wrap
hit_count  out  clog2(ROWS*COLS+1)  cells with PO&AT

Behaviour:
- Reset (clr=0, async): both planes 0, prescaler 0, row index 0, blink phase 0, frame counter 0, row_sel all 1, col_out 0, wr_ack/wr_err/frame_tick 0, hit_count 0.
- Prescaler counts 0..PRESC-1 and wraps. At terminal count the row index advances; ROWS-1 wraps to 0, and frame_tick pulses for one cycle in the cycle after the wrap edge.
- Blink: frame counter counts frame_ticks 0..BLINK_DIV-1. On wrap the blink phase toggles.
- Display outputs are registered and recomputed every cycle from the current row index and plane contents:
  - row_sel = ~(1<<row).
  - col_out by mode:
    - 00: PO[row].
    - 01: AT[row].
    - 10: (AT&~PO) | (PO&AT&{COLS{blink}}) | (PO&~AT&{COLS{blink}}). Misses steady; hits and unhit ships blink in phase.
    - 11: 0, and row_sel all 1.
- Write at cycle N (wr_en=1):
  - If wr_row<ROWS and wr_col<COLS: the plane bit updates at edge N+1 and wr_ack=1 during N+1.
  - Otherwise: no write, and wr_err=1 during N+1.
  - A write lands on col_out at edge N+2 if its row is currently displayed.
- layer_clr: the selected planes are zeroed at the next edge.
  - Same-cycle write to a cleared plane is dropped; wr_ack still pulses.
  - Any clear forces hit_count to 0, then recounts from subsequent writes.
  - A write to the non-cleared plane in the same cycle is applied, and hit_count counts it only if the other bit is 1 after the clear.
- hit_count is updated incrementally on the same edge as the write:
  - +1 when a write turns a cell from non-hit to hit.
  - -1 when a write turns a hit back to non-hit.
  - Rewriting the same value leaves it unchanged.
  - Never wraps: at most ROWS*COLS by construction.
- mode changes take effect on col_out at the next edge. Scan timing is unaffected by mode, writes, or clears.
- Reset asserted mid-frame returns everything to reset values immediately. The first row_sel/col_out are valid one edge after release.

Decomposition:
- Shared package: mode encodings (MODE_PO, MODE_AT, MODE_OVL, MODE_OFF), layer encodings (LAYER_PO, LAYER_AT), and a clog2-based width function.
- One sub-module: modulo_prescaler_varredura, containing the prescaler, row counter, frame counter, blink phase, and frame_tick, parametrised by ROWS, PRESC, and BLINK_DIV.
- Storage, write port, hit counter, and the output mux stay in the top.

Test Plan (ROWS=5, COLS=7, PRESC=4, BLINK_DIV=2):
- Reset release, idle -> row_sel steps 11110, 11101, 11011, 10111, 01111, 11110 every 4 cycles; frame_tick pulses every 20 cycles; col_out stays 0.
- Write PO(2,3)=1, mode 00 -> wr_ack the next cycle; when row 2 is driven, col_out=0001000; hit_count=0.
- Then write AT(2,3)=1 and AT(2,5)=1 with mode 10 -> hit_count=1. Row 2 col_out alternates between 0100000 and 0101000 every 2 frames (40 cycles).
- Write with wr_row=6, or wr_col=7 -> wr_err pulse; no wr_ack; planes and hit_count unchanged.
- layer_clr=10 in the same cycle as a write AT(0,0)=1 -> AT plane all 0, hit_count=0, wr_ack pulses; in mode 01 all col_out are 0.
- Assert clr mid-row 3 -> outputs immediately at reset values. After release, the scan restarts at row 0 and both planes read 0.
